// File: rtl/arm_mc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : arm_mc_pkg                                                       |
// | Brief    : Shared types and encodings for the multicycle ARM control unit.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package arm_mc_pkg;

   // The encoding is visible on state_o, so it must stay fixed.
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9,
      LINK   = 4'd10
   } state_t;

   localparam logic [1:0] c_ALU2_ADD = 2'b00;
   localparam logic [1:0] c_ALU2_SUB = 2'b01;
   localparam logic [1:0] c_ALU2_AND = 2'b10;
   localparam logic [1:0] c_ALU2_ORR = 2'b11;

   localparam logic [2:0] c_ALU3_ADD = 3'b000;
   localparam logic [2:0] c_ALU3_SUB = 3'b001;
   localparam logic [2:0] c_ALU3_AND = 3'b010;
   localparam logic [2:0] c_ALU3_ORR = 3'b011;
   localparam logic [2:0] c_ALU3_EOR = 3'b100;

   // Funct[4:1] command field values.
   localparam logic [3:0] c_CMD_AND = 4'b0000;
   localparam logic [3:0] c_CMD_EOR = 4'b0001;
   localparam logic [3:0] c_CMD_SUB = 4'b0010;
   localparam logic [3:0] c_CMD_ADD = 4'b0100;
   localparam logic [3:0] c_CMD_CMP = 4'b1010;
   localparam logic [3:0] c_CMD_ORR = 4'b1100;

   localparam logic [3:0] c_COND_EQ = 4'b0000;
   localparam logic [3:0] c_COND_NE = 4'b0001;
   localparam logic [3:0] c_COND_CS = 4'b0010;
   localparam logic [3:0] c_COND_CC = 4'b0011;
   localparam logic [3:0] c_COND_MI = 4'b0100;
   localparam logic [3:0] c_COND_PL = 4'b0101;
   localparam logic [3:0] c_COND_VS = 4'b0110;
   localparam logic [3:0] c_COND_VC = 4'b0111;
   localparam logic [3:0] c_COND_HI = 4'b1000;
   localparam logic [3:0] c_COND_LS = 4'b1001;
   localparam logic [3:0] c_COND_GE = 4'b1010;
   localparam logic [3:0] c_COND_LT = 4'b1011;
   localparam logic [3:0] c_COND_GT = 4'b1100;
   localparam logic [3:0] c_COND_LE = 4'b1101;
   localparam logic [3:0] c_COND_AL = 4'b1110;

endpackage
`default_nettype wire

// File: rtl/arm_cond_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : arm_cond_unit                                                    |
// | Brief    : NZCV flag registers and condition evaluation.                    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module arm_cond_unit
   import arm_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       flagEn,
   input  logic       condLatch,
   output logic       CondEx
);

   logic [1:0] r_nz;
   logic [1:0] r_cv;
   logic       r_condEx;
   logic       w_condEx;
   logic       w_n, w_z, w_c, w_v;

   assign {w_n, w_z} = r_nz;
   assign {w_c, w_v} = r_cv;

   always_comb begin
      w_condEx = 1'b0;
      case (Cond)
         c_COND_EQ: w_condEx = w_z;
         c_COND_NE: w_condEx = ~w_z;
         c_COND_CS: w_condEx = w_c;
         c_COND_CC: w_condEx = ~w_c;
         c_COND_MI: w_condEx = w_n;
         c_COND_PL: w_condEx = ~w_n;
         c_COND_VS: w_condEx = w_v;
         c_COND_VC: w_condEx = ~w_v;
         c_COND_HI: w_condEx = w_c & ~w_z;
         c_COND_LS: w_condEx = ~w_c | w_z;
         c_COND_GE: w_condEx = (w_n == w_v);
         c_COND_LT: w_condEx = (w_n != w_v);
         c_COND_GT: w_condEx = ~w_z & (w_n == w_v);
         c_COND_LE: w_condEx = w_z | (w_n != w_v);
         c_COND_AL: w_condEx = 1'b1;
         default:   w_condEx = 1'b0;
      endcase
   end

   // The verdict is frozen in DECODE so a flag-setting instruction is
   // judged against the flags that existed before it executed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nz     <= 2'b00;
         r_cv     <= 2'b00;
         r_condEx <= 1'b0;
      end else begin
         if (condLatch)
            r_condEx <= w_condEx;
         if (flagEn && FlagW[1] && r_condEx)
            r_nz <= ALUFlags[3:2];
         if (flagEn && FlagW[0] && r_condEx)
            r_cv <= ALUFlags[1:0];
      end
   end

   assign CondEx = r_condEx;

endmodule
`default_nettype wire

// File: rtl/arm_mc_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : arm_mc_controller                                                |
// | Brief    : Multicycle ARM control unit: main FSM, ALU decoder, gating.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module arm_mc_controller
   import arm_mc_pkg::*;
#(
   parameter int ALUCTRL_W = 2,
   parameter bit EN_BL     = 1'b0
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           Cond,
   input  logic [1:0]           Op,
   input  logic [5:0]           Funct,
   input  logic [3:0]           Rd,
   input  logic [3:0]           ALUFlags,
   output logic                 PCWrite,
   output logic                 MemWrite,
   output logic                 RegWrite,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 LinkWrite,
   output logic [3:0]           state_o
);

   localparam bit c_W3 = (ALUCTRL_W == 3);

   state_t r_state;
   state_t w_next;
   state_t w_decState;

   logic w_condEx;
   logic w_aluOp;
   logic w_pcw, w_mw, w_rw, w_irw, w_lw;
   logic w_cmdSub, w_cmdAnd, w_cmdOrr, w_cmdEor;
   logic w_noWrite, w_addSub;
   logic [1:0] w_flagW;
   logic [ALUCTRL_W-1:0] w_aluSel;

   always_comb begin
      w_next = FETCH;
      case (r_state)
         FETCH:  w_next = DECODE;
         DECODE: begin
            case (Op)
               2'b01:   w_next = MEMADR;
               2'b00:   w_next = Funct[5] ? EXECI : EXECR;
               2'b10:   w_next = (EN_BL && Funct[4]) ? LINK : BRANCH;
               default: w_next = FETCH;
            endcase
         end
         MEMADR:  w_next = Funct[0] ? MEMRD : MEMWR;
         MEMRD:   w_next = MEMWB;
         EXECR,
         EXECI:   w_next = ALUWB;
         LINK:    w_next = BRANCH;
         default: w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= FETCH;
      else
         r_state <= w_next;
   end

   // Reset presents FETCH-state selects even while the register still holds
   // the aborted state.
   assign w_decState = reset ? FETCH : r_state;
   assign state_o    = w_decState;

   always_comb begin
      w_pcw     = 1'b0;
      w_mw      = 1'b0;
      w_rw      = 1'b0;
      w_irw     = 1'b0;
      w_lw      = 1'b0;
      w_aluOp   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (w_decState)
         FETCH: begin
            w_irw     = 1'b1;
            w_pcw     = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: ALUSrcB = 2'b01;
         MEMRD:  AdrSrc  = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            w_rw      = w_condEx;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            w_mw   = w_condEx;
         end
         EXECR: w_aluOp = 1'b1;
         EXECI: begin
            ALUSrcB = 2'b01;
            w_aluOp = 1'b1;
         end
         ALUWB: begin
            if (!w_noWrite) begin
               if (Rd == 4'hF)
                  w_pcw = w_condEx;
               else
                  w_rw  = w_condEx;
            end
         end
         BRANCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            w_pcw     = w_condEx;
         end
         LINK: begin
            w_lw = EN_BL;
            w_rw = w_condEx;
         end
         default: ;
      endcase
   end

   assign PCWrite   = ~reset & w_pcw;
   assign MemWrite  = ~reset & w_mw;
   assign RegWrite  = ~reset & w_rw;
   assign IRWrite   = ~reset & w_irw;
   assign LinkWrite = ~reset & w_lw;
   assign ImmSrc    = Op;
   assign RegSrc    = {Op == 2'b01, Op == 2'b10};

   always_comb begin
      w_cmdSub  = 1'b0;
      w_cmdAnd  = 1'b0;
      w_cmdOrr  = 1'b0;
      w_cmdEor  = 1'b0;
      w_noWrite = 1'b0;
      w_addSub  = 1'b0;
      case (Funct[4:1])
         c_CMD_ADD: w_addSub = 1'b1;
         c_CMD_SUB: begin
            w_cmdSub = 1'b1;
            w_addSub = 1'b1;
         end
         c_CMD_AND: w_cmdAnd = 1'b1;
         c_CMD_ORR: w_cmdOrr = 1'b1;
         c_CMD_EOR: w_cmdEor = 1'b1;
         c_CMD_CMP: begin
            w_cmdSub  = c_W3;
            w_noWrite = c_W3;
            w_addSub  = c_W3;
         end
         default: ;
      endcase
   end

   assign w_flagW = {Funct[0], Funct[0] & w_addSub};

   if (ALUCTRL_W == 3) begin : g_alu3
      assign w_aluSel = w_cmdEor ? c_ALU3_EOR :
                        w_cmdOrr ? c_ALU3_ORR :
                        w_cmdAnd ? c_ALU3_AND :
                        w_cmdSub ? c_ALU3_SUB : c_ALU3_ADD;
      assign ALUControl = w_aluOp ? w_aluSel : c_ALU3_ADD;
   end else begin : g_alu2
      // EOR has no encoding at this width and falls back to ADD.
      assign w_aluSel = w_cmdEor ? c_ALU2_ADD :
                        w_cmdOrr ? c_ALU2_ORR :
                        w_cmdAnd ? c_ALU2_AND :
                        w_cmdSub ? c_ALU2_SUB : c_ALU2_ADD;
      assign ALUControl = w_aluOp ? w_aluSel : c_ALU2_ADD;
   end

   arm_cond_unit u_cond (
      .clk       (clk),
      .reset     (reset),
      .Cond      (Cond),
      .ALUFlags  (ALUFlags),
      .FlagW     (w_flagW),
      .flagEn    (w_aluOp),
      .condLatch (r_state == DECODE),
      .CondEx    (w_condEx)
   );

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_arm_mc_controller                                             |
// | Brief    : Scoreboard bench for arm_mc_controller (ALUCTRL_W=3, EN_BL=1).   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_arm_mc_controller;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                          S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                          S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                          S_BRANCH = 4'd9, S_LINK = 4'd10;
   // {PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite}
   localparam logic [4:0] W_NONE = 5'b00000, W_PC = 5'b10000, W_MEM = 5'b01000,
                          W_REG = 5'b00100, W_FETCH = 5'b10010, W_LINK = 5'b00101;
   localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_ORR = 3'b011, A_EOR = 3'b100;
   localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_MI = 4'b0100,
                          C_PL = 4'b0101, C_AL = 4'b1110, C_NV = 4'b1111;

   logic clk = 1'b0;
   logic reset;
   logic [3:0] Cond, Rd, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, LinkWrite;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [2:0] ALUControl;
   logic [3:0] state_o;

   always #5 clk = ~clk;

   arm_mc_controller #(.ALUCTRL_W(3), .EN_BL(1'b1)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .ALUControl(ALUControl), .LinkWrite(LinkWrite), .state_o(state_o)
   );

   // [21:18] state [17:13] enables [12] AdrSrc [11] ALUSrcA [10:9] ResultSrc
   // [8:7] ALUSrcB [6:4] ALUControl [3:2] ImmSrc [1:0] RegSrc
   logic [21:0] act;
   assign act = {state_o, PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite, AdrSrc,
                 ALUSrcA, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc};

   typedef struct {
      logic [21:0] val;
      logic [21:0] mask;
      string       tag;
   } exp_t;

   exp_t q[$];
   int nApplied = 0;
   int nMis = 0;

   function automatic exp_t mk(input logic [3:0] st, input logic [4:0] we,
                               input logic [2:0] alu, input string tag);
      exp_t e;
      e.tag  = tag;
      e.val  = '0;
      e.mask = 22'h3FE07F;
      e.val[21:18] = st;
      e.val[17:13] = we;
      e.val[6:4]   = alu;
      e.val[3:2]   = Op;
      e.val[1:0]   = {Op == 2'b01, Op == 2'b10};
      case (st)
         S_FETCH: begin
            e.val[12] = 1'b0; e.val[11] = 1'b1; e.val[10:9] = 2'b10; e.val[8:7] = 2'b10;
            e.mask[12:7] = 6'h3F;
         end
         S_DECODE: begin
            e.val[11] = 1'b1; e.val[10:9] = 2'b10; e.val[8:7] = 2'b10;
            e.mask[11:7] = 5'h1F;
         end
         S_MEMADR: begin e.val[8:7] = 2'b01; e.mask[8:7] = 2'b11; end
         S_MEMRD:  begin e.val[12] = 1'b1; e.mask[12] = 1'b1; end
         S_MEMWB:  begin e.val[10:9] = 2'b01; e.mask[10:9] = 2'b11; end
         S_MEMWR:  begin e.val[12] = 1'b1; e.mask[12] = 1'b1; end
         S_EXECR:  begin e.val[8:7] = 2'b00; e.mask[8:7] = 2'b11; end
         S_EXECI:  begin e.val[8:7] = 2'b01; e.mask[8:7] = 2'b11; end
         S_ALUWB:  begin e.val[10:9] = 2'b00; e.mask[10:9] = 2'b11; end
         S_BRANCH: begin
            e.val[11] = 1'b0; e.val[10:9] = 2'b10; e.val[8:7] = 2'b10;
            e.mask[11:7] = 5'h1F;
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic cyc(input logic [3:0] st, input logic [4:0] we,
                      input logic [2:0] alu, input string tag);
      q.push_back(mk(st, we, alu, tag));
      @(posedge clk);
      #1;
   endtask

   task automatic setI(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] fl);
      Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = fl;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            nApplied++;
            if (((act ^ e.val) & e.mask) !== 22'h0) begin
               nMis++;
               $display("FAIL %s: got %h, expected %h (care mask %h)", e.tag, act, e.val, e.mask);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      setI(C_AL, 2'b00, 6'b101000, 4'd1, 4'b0000);
      @(posedge clk); #1;
      repeat (3) cyc(S_FETCH, W_NONE, A_ADD, "reset");
      reset = 1'b0;

      // ADD R1,R2,#5
      cyc(S_FETCH, W_FETCH, A_ADD, "add.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "add.decode");
      cyc(S_EXECI, W_NONE, A_ADD, "add.execi");
      cyc(S_ALUWB, W_REG, A_ADD, "add.aluwb");

      setI(C_AL, 2'b01, 6'b011001, 4'd3, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "ldr.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "ldr.decode");
      cyc(S_MEMADR, W_NONE, A_ADD, "ldr.memadr");
      cyc(S_MEMRD, W_NONE, A_ADD, "ldr.memrd");
      cyc(S_MEMWB, W_REG, A_ADD, "ldr.memwb");

      setI(C_AL, 2'b01, 6'b011000, 4'd3, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "str.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "str.decode");
      cyc(S_MEMADR, W_NONE, A_ADD, "str.memadr");
      cyc(S_MEMWR, W_MEM, A_ADD, "str.memwr");

      // SUBS sets Z, BEQ taken
      setI(C_AL, 2'b00, 6'b000101, 4'd2, 4'b0100);
      cyc(S_FETCH, W_FETCH, A_ADD, "subs1.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "subs1.decode");
      cyc(S_EXECR, W_NONE, A_SUB, "subs1.execr");
      cyc(S_ALUWB, W_REG, A_ADD, "subs1.aluwb");
      setI(C_EQ, 2'b10, 6'b100000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "beq1.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "beq1.decode");
      cyc(S_BRANCH, W_PC, A_ADD, "beq1.branch");

      // SUBS clears Z, BEQ not taken
      setI(C_AL, 2'b00, 6'b000101, 4'd2, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "subs2.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "subs2.decode");
      cyc(S_EXECR, W_NONE, A_SUB, "subs2.execr");
      cyc(S_ALUWB, W_REG, A_ADD, "subs2.aluwb");
      setI(C_EQ, 2'b10, 6'b100000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "beq2.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "beq2.decode");
      cyc(S_BRANCH, W_NONE, A_ADD, "beq2.branch");

      // CMP sets N without writing a register
      setI(C_AL, 2'b00, 6'b010101, 4'd0, 4'b1000);
      cyc(S_FETCH, W_FETCH, A_ADD, "cmp.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "cmp.decode");
      cyc(S_EXECR, W_NONE, A_SUB, "cmp.execr");
      cyc(S_ALUWB, W_NONE, A_ADD, "cmp.aluwb");
      setI(C_MI, 2'b10, 6'b100000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "bmi1.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "bmi1.decode");
      cyc(S_BRANCH, W_PC, A_ADD, "bmi1.branch");
      setI(C_PL, 2'b10, 6'b100000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "bpl.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "bpl.decode");
      cyc(S_BRANCH, W_NONE, A_ADD, "bpl.branch");

      // SUBSMI clears N but is judged on the old N=1
      setI(C_MI, 2'b00, 6'b000101, 4'd4, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "subsmi.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "subsmi.decode");
      cyc(S_EXECR, W_NONE, A_SUB, "subsmi.execr");
      cyc(S_ALUWB, W_REG, A_ADD, "subsmi.aluwb");
      setI(C_MI, 2'b10, 6'b100000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "bmi2.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "bmi2.decode");
      cyc(S_BRANCH, W_NONE, A_ADD, "bmi2.branch");

      setI(C_AL, 2'b00, 6'b000010, 4'd5, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "eor.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "eor.decode");
      cyc(S_EXECR, W_NONE, A_EOR, "eor.execr");
      cyc(S_ALUWB, W_REG, A_ADD, "eor.aluwb");

      setI(C_AL, 2'b00, 6'b111000, 4'd6, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "orr.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "orr.decode");
      cyc(S_EXECI, W_NONE, A_ORR, "orr.execi");
      cyc(S_ALUWB, W_REG, A_ADD, "orr.aluwb");

      setI(C_AL, 2'b10, 6'b010000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "bl.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "bl.decode");
      cyc(S_LINK, W_LINK, A_ADD, "bl.link");
      cyc(S_BRANCH, W_PC, A_ADD, "bl.branch");

      // Rd=15 redirects the write to the PC
      setI(C_AL, 2'b00, 6'b101000, 4'd15, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "pcdst.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "pcdst.decode");
      cyc(S_EXECI, W_NONE, A_ADD, "pcdst.execi");
      cyc(S_ALUWB, W_PC, A_ADD, "pcdst.aluwb");

      setI(C_NV, 2'b00, 6'b101000, 4'd7, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "nv.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "nv.decode");
      cyc(S_EXECI, W_NONE, A_ADD, "nv.execi");
      cyc(S_ALUWB, W_NONE, A_ADD, "nv.aluwb");

      setI(C_AL, 2'b11, 6'b000000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "undef.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "undef.decode");

      // STREQ with Z=0: store suppressed
      setI(C_EQ, 2'b01, 6'b011000, 4'd3, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "streq.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "streq.decode");
      cyc(S_MEMADR, W_NONE, A_ADD, "streq.memadr");
      cyc(S_MEMWR, W_NONE, A_ADD, "streq.memwr");

      // Set Z, then abort a STR in MEMWR; reset must also clear Z
      setI(C_AL, 2'b00, 6'b000101, 4'd2, 4'b0100);
      cyc(S_FETCH, W_FETCH, A_ADD, "subs3.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "subs3.decode");
      cyc(S_EXECR, W_NONE, A_SUB, "subs3.execr");
      cyc(S_ALUWB, W_REG, A_ADD, "subs3.aluwb");
      setI(C_AL, 2'b01, 6'b011000, 4'd3, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "strab.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "strab.decode");
      cyc(S_MEMADR, W_NONE, A_ADD, "strab.memadr");
      reset = 1'b1;
      cyc(S_FETCH, W_NONE, A_ADD, "strab.reset");
      reset = 1'b0;
      setI(C_NE, 2'b10, 6'b100000, 4'd0, 4'b0000);
      cyc(S_FETCH, W_FETCH, A_ADD, "bne.fetch");
      cyc(S_DECODE, W_NONE, A_ADD, "bne.decode");
      cyc(S_BRANCH, W_PC, A_ADD, "bne.branch");

      for (int i = 0; i < 20 && q.size() > 0; i++)
         @(negedge clk);
      if (q.size() > 0) begin
         nMis++;
         $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMis);
      $finish;
   end

endmodule
`default_nettype wire
